// File: rtl/memory_pkg.sv
// Shared defaults and state encoding for the memory sequencer.
// No logic; imported by the interface, the sequencer and its counter.
package memory_pkg;

   localparam int DEF_DATA_W      = 48;
   localparam int DEF_ADDR_W      = 3;
   localparam int DEF_WAIT_CYCLES = 8;

   localparam logic [2:0] ST_INIT_WR    = 3'd0;
   localparam logic [2:0] ST_IDLE       = 3'd1;
   localparam logic [2:0] ST_READ_WAIT  = 3'd2;
   localparam logic [2:0] ST_LOAD       = 3'd3;
   localparam logic [2:0] ST_HOLD       = 3'd4;
   localparam logic [2:0] ST_WRITE_WAIT = 3'd5;

   typedef enum logic [2:0] {
      INIT_WR    = ST_INIT_WR,
      IDLE       = ST_IDLE,
      READ_WAIT  = ST_READ_WAIT,
      LOAD       = ST_LOAD,
      HOLD       = ST_HOLD,
      WRITE_WAIT = ST_WRITE_WAIT
   } state_e;

   // Wide enough to hold the terminal value WAIT_CYCLES-1 even when WAIT_CYCLES is a power of two.
   function automatic int wait_cnt_width(input int wait_cycles);
      return $clog2(wait_cycles + 1);
   endfunction

endpackage

// File: rtl/memory_sequencer_if.sv
// Request/response and memory-side signals of the sequencer.
// master = controlling datapath side, slave = sequencer.
interface memory_sequencer_if
   import memory_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              init_req;
   logic              load_req;
   logic [ADDR_W-1:0] load_addr;
   logic              commit;
   logic              abort;
   logic [DATA_W-1:0] init_data;
   logic [DATA_W-1:0] datapath_out;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              write_enable;
   logic              load_registers;
   logic              done;
   logic              finished_init;
   logic              busy;

   modport master (
      output init_req, load_req, load_addr, commit, abort, init_data, datapath_out,
      input  mem_addr, mem_data, write_enable, load_registers, done, finished_init, busy
   );

   modport slave (
      input  init_req, load_req, load_addr, commit, abort, init_data, datapath_out,
      output mem_addr, mem_data, write_enable, load_registers, done, finished_init, busy
   );

endinterface

// File: rtl/wait_counter.sv
// Free-running access-hold counter; tc flags count == LIMIT.
// clear has priority over enable and returns the count to zero on the next edge.
module wait_counter #(
   parameter int WIDTH = 4,
   parameter int LIMIT = 7
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == LIMIT[WIDTH-1:0]);

endmodule

// File: rtl/memory_sequencer.sv
// Init sweep, timed read, single-cycle load strobe and write-back sequencer for a small memory.
// Each timed access holds for WAIT_CYCLES cycles; HOLD waits for commit/abort indefinitely.
module memory_sequencer
   import memory_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input logic              clock,
   input logic              reset,
   memory_sequencer_if.slave bus
);

   localparam int CNT_W = wait_cnt_width(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              tc;
   logic              timed;
   logic              cnt_clear;

   assign timed = (state_q == INIT_WR) || (state_q == READ_WAIT) || (state_q == WRITE_WAIT);
   // A terminal count inside INIT_WR restarts the window for the next address.
   assign cnt_clear = (state_d != state_q) || tc;

   wait_counter #(
      .WIDTH (CNT_W),
      .LIMIT (WAIT_CYCLES - 1)
   ) u_wait_counter (
      .clock  (clock),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (timed),
      .tc     (tc)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      case (state_q)
         INIT_WR: begin
            if (tc) begin
               if (&ptr_q) begin
                  state_d = IDLE;
                  ptr_d   = '0;
               end else begin
                  ptr_d = ptr_q + ADDR_W'(1);
               end
            end
         end
         IDLE: begin
            if (bus.init_req) begin
               state_d = INIT_WR;
               ptr_d   = '0;
            end else if (bus.load_req) begin
               state_d = READ_WAIT;
               addr_d  = bus.load_addr;
            end
         end
         READ_WAIT: begin
            if (tc) state_d = LOAD;
         end
         LOAD: begin
            state_d = HOLD;
         end
         HOLD: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (bus.commit) begin
               state_d = WRITE_WAIT;
            end
         end
         WRITE_WAIT: begin
            if (tc) state_d = IDLE;
         end
         default: begin
            state_d = INIT_WR;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= INIT_WR;
         ptr_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
      end
   end

   // Everything except mem_data is decoded from registered state only.
   assign bus.mem_addr       = (state_q == INIT_WR) ? ptr_q : addr_q;
   assign bus.mem_data       = (state_q == INIT_WR) ? DATA_W'(bus.init_data)
                                                    : DATA_W'(bus.datapath_out);
   assign bus.write_enable   = (state_q == INIT_WR) || (state_q == WRITE_WAIT);
   assign bus.load_registers = (state_q == LOAD);
   assign bus.done           = (state_q == IDLE);
   assign bus.finished_init  = (state_q != INIT_WR);
   assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_memory_sequencer.sv
// Directed bench for memory_sequencer with DATA_W=48, ADDR_W=2, WAIT_CYCLES=4.
module tb_memory_sequencer;

   localparam int DW = 48;
   localparam int AW = 2;
   localparam int WC = 4;

   logic clock = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   memory_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   memory_sequencer #(
      .DATA_W      (DW),
      .ADDR_W      (AW),
      .WAIT_CYCLES (WC)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input logic [AW-1:0] a);
      bus.load_addr = a;
      bus.load_req  = 1'b1;
      tick();
      bus.load_req  = 1'b0;
      repeat (WC + 1) tick();
   endtask

   task automatic test_reset();
      bus.init_data = 48'hAAAAAAAAAAAA;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++; if (bus.load_registers !== 1'b0) begin miscompares++; $display("FAIL rst_lr got=%b exp=0", bus.load_registers); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_done got=%b exp=0", bus.done); end
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rst_busy got=%b exp=1", bus.busy); end
      for (int i = 0; i < 16; i++) begin
         vectors++; if (bus.write_enable !== 1'b1) begin miscompares++; $display("FAIL init_we[%0d] got=%b exp=1", i, bus.write_enable); end
         vectors++; if (bus.mem_addr !== AW'(i / 4)) begin miscompares++; $display("FAIL init_addr[%0d] got=%0d exp=%0d", i, bus.mem_addr, i / 4); end
         vectors++; if (bus.mem_data !== 48'hAAAAAAAAAAAA) begin miscompares++; $display("FAIL init_data[%0d] got=%h", i, bus.mem_data); end
         vectors++; if (bus.finished_init !== 1'b0) begin miscompares++; $display("FAIL init_fi[%0d] got=%b exp=0", i, bus.finished_init); end
         tick();
      end
      vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL init_end_done got=%b exp=1", bus.done); end
      vectors++; if (bus.finished_init !== 1'b1) begin miscompares++; $display("FAIL init_end_fi got=%b exp=1", bus.finished_init); end
      vectors++; if (bus.write_enable !== 1'b0) begin miscompares++; $display("FAIL init_end_we got=%b exp=0", bus.write_enable); end
   endtask

   task automatic test_load();
      bus.load_addr = 2'd2;
      bus.load_req  = 1'b1;
      tick();
      bus.load_req  = 1'b0;
      bus.load_addr = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         vectors++; if (bus.mem_addr !== 2'd2) begin miscompares++; $display("FAIL rd_addr[T+%0d] got=%0d exp=2", i, bus.mem_addr); end
         vectors++; if (bus.load_registers !== 1'b0) begin miscompares++; $display("FAIL rd_lr[T+%0d] got=%b exp=0", i, bus.load_registers); end
         vectors++; if (bus.write_enable !== 1'b0) begin miscompares++; $display("FAIL rd_we[T+%0d] got=%b exp=0", i, bus.write_enable); end
         vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rd_done[T+%0d] got=%b exp=0", i, bus.done); end
         tick();
      end
      vectors++; if (bus.load_registers !== 1'b1) begin miscompares++; $display("FAIL load_lr got=%b exp=1", bus.load_registers); end
      vectors++; if (bus.mem_addr !== 2'd2) begin miscompares++; $display("FAIL load_addr got=%0d exp=2", bus.mem_addr); end
      vectors++; if (bus.write_enable !== 1'b0) begin miscompares++; $display("FAIL load_we got=%b exp=0", bus.write_enable); end
      tick();
      vectors++; if (bus.load_registers !== 1'b0) begin miscompares++; $display("FAIL hold_lr got=%b exp=0", bus.load_registers); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL hold_done got=%b exp=0", bus.done); end
      vectors++; if (bus.write_enable !== 1'b0) begin miscompares++; $display("FAIL hold_we got=%b exp=0", bus.write_enable); end
   endtask

   task automatic test_hold_ignore();
      bus.init_req = 1'b1;
      bus.load_req = 1'b1;
      tick();
      bus.init_req = 1'b0;
      bus.load_req = 1'b0;
      repeat (10) tick();
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL hold_ign_done got=%b exp=0", bus.done); end
      vectors++; if (bus.finished_init !== 1'b1) begin miscompares++; $display("FAIL hold_ign_fi got=%b exp=1", bus.finished_init); end
      vectors++; if (bus.mem_addr !== 2'd2) begin miscompares++; $display("FAIL hold_ign_addr got=%0d exp=2", bus.mem_addr); end
   endtask

   task automatic test_commit();
      bus.datapath_out = 48'h123456789ABC;
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         vectors++; if (bus.write_enable !== 1'b1) begin miscompares++; $display("FAIL wr_we[C+%0d] got=%b exp=1", i, bus.write_enable); end
         vectors++; if (bus.mem_addr !== 2'd2) begin miscompares++; $display("FAIL wr_addr[C+%0d] got=%0d exp=2", i, bus.mem_addr); end
         vectors++; if (bus.mem_data !== 48'h123456789ABC) begin miscompares++; $display("FAIL wr_data[C+%0d] got=%h exp=123456789abc", i, bus.mem_data); end
         tick();
      end
      vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL wr_done got=%b exp=1", bus.done); end
      vectors++; if (bus.write_enable !== 1'b0) begin miscompares++; $display("FAIL wr_end_we got=%b exp=0", bus.write_enable); end
      bus.datapath_out = 48'hDEADBEEF0001;
      #1;
      vectors++; if (bus.mem_data !== 48'hDEADBEEF0001) begin miscompares++; $display("FAIL idle_passthru got=%h exp=deadbeef0001", bus.mem_data); end
   endtask

   task automatic test_abort();
      do_load(2'd1);
      bus.commit = 1'b1;
      bus.abort  = 1'b1;
      tick();
      bus.commit = 1'b0;
      bus.abort  = 1'b0;
      vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL abort_done got=%b exp=1", bus.done); end
      vectors++; if (bus.write_enable !== 1'b0) begin miscompares++; $display("FAIL abort_we got=%b exp=0", bus.write_enable); end
      vectors++; if (bus.mem_addr !== 2'd1) begin miscompares++; $display("FAIL abort_addr got=%0d exp=1", bus.mem_addr); end
   endtask

   task automatic test_init_priority();
      int lr_seen;
      lr_seen = 0;
      bus.init_data = 48'h0F0F0F0F0F0F;
      bus.load_addr = 2'd3;
      bus.init_req  = 1'b1;
      bus.load_req  = 1'b1;
      tick();
      bus.init_req  = 1'b0;
      bus.load_req  = 1'b0;
      vectors++; if (bus.finished_init !== 1'b0) begin miscompares++; $display("FAIL prio_fi got=%b exp=0", bus.finished_init); end
      vectors++; if (bus.mem_addr !== 2'd0) begin miscompares++; $display("FAIL prio_addr got=%0d exp=0", bus.mem_addr); end
      vectors++; if (bus.write_enable !== 1'b1) begin miscompares++; $display("FAIL prio_we got=%b exp=1", bus.write_enable); end
      for (int i = 1; i < 16; i++) begin
         tick();
         if (bus.load_registers !== 1'b0) lr_seen++;
      end
      tick();
      vectors++; if (lr_seen !== 0) begin miscompares++; $display("FAIL prio_no_load got=%0d strobes exp=0", lr_seen); end
      vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL prio_done got=%b exp=1", bus.done); end
      vectors++; if (bus.mem_addr !== 2'd1) begin miscompares++; $display("FAIL prio_latched got=%0d exp=1", bus.mem_addr); end
   endtask

   task automatic test_reset_mid_write();
      bus.init_data = 48'h555555555555;
      do_load(2'd3);
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
      tick();
      vectors++; if (bus.write_enable !== 1'b1) begin miscompares++; $display("FAIL mid_wr_we got=%b exp=1", bus.write_enable); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++; if (bus.finished_init !== 1'b0) begin miscompares++; $display("FAIL mid_rst_fi got=%b exp=0", bus.finished_init); end
      vectors++; if (bus.mem_addr !== 2'd0) begin miscompares++; $display("FAIL mid_rst_addr got=%0d exp=0", bus.mem_addr); end
      vectors++; if (bus.mem_data !== 48'h555555555555) begin miscompares++; $display("FAIL mid_rst_data got=%h exp=555555555555", bus.mem_data); end
      vectors++; if (bus.write_enable !== 1'b1) begin miscompares++; $display("FAIL mid_rst_we got=%b exp=1", bus.write_enable); end
   endtask

   initial begin
      reset            = 1'b1;
      bus.init_req     = 1'b0;
      bus.load_req     = 1'b0;
      bus.load_addr    = '0;
      bus.commit       = 1'b0;
      bus.abort        = 1'b0;
      bus.init_data    = '0;
      bus.datapath_out = '0;
      test_reset();
      test_load();
      test_hold_ignore();
      test_commit();
      test_abort();
      test_init_priority();
      test_reset_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
